// File: rtl/mem_access_sequencer_if.sv
// Decode/cache/memory signal bundle for mem_access_sequencer.
// The statistics counters exist only when MEM_STATS_EN is defined.
// master: the sequencer (drives control, samples decode and cache status).
// slave : the pipeline/cache side (drives decode and cache status).
// Handshake: there is no valid/ready pair. A memory instruction is "offered" while
// is_load|is_store is high in an IDLE cycle, and it is "accepted" (retired) in the
// cycle pc_we is high. The offering side must hold the decode inputs stable until
// it sees pc_we.
interface mem_access_sequencer_if;
  logic        is_load;
  logic        is_store;
  logic        is_byte;
  logic        cache_hit;
  logic        victim_dirty;
  logic        pc_we;
  logic        reg_we_mem;
  logic        cache_we;
  logic        cache_byte;
  logic        cache_fill;
  logic        mem_re;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        busy;
  logic [1:0]  seq_state;     // debug view of the sequencer FSM state
`ifdef MEM_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic [31:0] wb_count;
`endif

  modport master (
    input  is_load, is_store, is_byte, cache_hit, victim_dirty,
    output pc_we, reg_we_mem, cache_we, cache_byte, cache_fill,
    output mem_re, mem_we, mem_addr_sel, busy, seq_state
`ifdef MEM_STATS_EN
    , output hit_count, miss_count, wb_count
`endif
  );

  modport slave (
    output is_load, is_store, is_byte, cache_hit, victim_dirty,
    input  pc_we, reg_we_mem, cache_we, cache_byte, cache_fill,
    input  mem_re, mem_we, mem_addr_sel, busy, seq_state
`ifdef MEM_STATS_EN
    , input hit_count, miss_count, wb_count
`endif
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Multi-cycle sequencer for LW/SW/LB/SB.
// A cache hit retires in one cycle. A miss stalls the PC, writes back a dirty
// victim if there is one (WRITEBACK), refills the line (REFILL), and then
// re-evaluates the held instruction in IDLE.
// Optional feature macro: MEM_STATS_EN adds the hit/miss/writeback counters.
module mem_access_sequencer #(
  parameter int MEM_LATENCY = 4,
  parameter int CNT_W       = $clog2(MEM_LATENCY + 1)
) (
  input logic                    clk,
  input logic                    rst_b,
  mem_access_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(MEM_LATENCY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mem_inst;
  logic             idle_miss;
  logic             last_xfer;

  assign mem_inst  = bus.is_load | bus.is_store;
  assign idle_miss = (state == IDLE) & mem_inst & ~bus.cache_hit;
  assign last_xfer = (cnt == '0);
  assign bus.seq_state = state;

  // State and latency counter. Decode inputs only influence the IDLE decision.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_miss) begin
            state <= bus.victim_dirty ? WRITEBACK : REFILL;
            cnt   <= CNT_RELOAD;
          end
        end
        WRITEBACK: begin
          if (last_xfer) begin
            state <= REFILL;
            cnt   <= CNT_RELOAD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        REFILL: begin
          if (last_xfer) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Control outputs. A hit must retire in the cycle the decode arrives, so the
  // IDLE outputs depend on the live decode inputs; every output is held low
  // whenever rst_b is low.
  always_comb begin
    bus.pc_we        = 1'b0;
    bus.reg_we_mem   = 1'b0;
    bus.cache_we     = 1'b0;
    bus.cache_byte   = 1'b0;
    bus.cache_fill   = 1'b0;
    bus.mem_re       = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.busy         = 1'b0;
    if (rst_b) begin
      bus.busy = (state != IDLE);
      case (state)
        IDLE: begin
          if (!mem_inst) begin
            bus.pc_we = 1'b1;
          end else if (bus.cache_hit) begin
            bus.pc_we      = 1'b1;
            bus.cache_byte = bus.is_byte;
            // A simultaneous load+store decode is treated as a store.
            if (bus.is_store) bus.cache_we   = 1'b1;
            else              bus.reg_we_mem = 1'b1;
          end
        end
        WRITEBACK: begin
          bus.mem_we       = 1'b1;
          bus.mem_addr_sel = 1'b1;
        end
        REFILL: begin
          bus.mem_re     = 1'b1;
          bus.cache_fill = last_xfer;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic [31:0] wb_cnt;
  logic        retry;

  // Statistics. The retry flag marks the IDLE cycle right after a refill so the
  // completing access of a miss is not also counted as a hit.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
      retry    <= 1'b0;
    end else begin
      if (state == IDLE) begin
        retry <= 1'b0;
        if (mem_inst && bus.cache_hit && !retry) hit_cnt <= hit_cnt + 32'd1;
        if (idle_miss)                           miss_cnt <= miss_cnt + 32'd1;
        if (idle_miss && bus.victim_dirty)       wb_cnt <= wb_cnt + 32'd1;
      end
      if (state == REFILL && last_xfer) retry <= 1'b1;
    end
  end

  assign bus.hit_count  = hit_cnt;
  assign bus.miss_count = miss_cnt;
  assign bus.wb_count   = wb_cnt;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: two instances (MEM_LATENCY 4 and 1) share the
// same decode/cache stimulus. The reference model plans each miss as a queue of
// expected per-cycle output vectors built from the documented latencies.
`timescale 1ns/1ps
module tb_mem_access_sequencer;

  // {pc_we, reg_we_mem, cache_we, cache_byte, cache_fill, mem_re, mem_we, mem_addr_sel, busy}
  typedef logic [8:0] vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_b;
  logic is_load, is_store, is_byte, cache_hit, victim_dirty;

  always #5 clk = ~clk;

  mem_access_sequencer_if bus4();
  mem_access_sequencer_if bus1();

  assign bus4.is_load = is_load;  assign bus1.is_load = is_load;
  assign bus4.is_store = is_store; assign bus1.is_store = is_store;
  assign bus4.is_byte = is_byte;  assign bus1.is_byte = is_byte;
  assign bus4.cache_hit = cache_hit; assign bus1.cache_hit = cache_hit;
  assign bus4.victim_dirty = victim_dirty; assign bus1.victim_dirty = victim_dirty;

  mem_access_sequencer #(.MEM_LATENCY(4)) dut4 (.clk(clk), .rst_b(rst_b), .bus(bus4));
  mem_access_sequencer #(.MEM_LATENCY(1)) dut1 (.clk(clk), .rst_b(rst_b), .bus(bus1));

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [8:0] exp_q4[$];
  logic [8:0] exp_q1[$];
  int exp_hit[2];
  int exp_miss[2];
  int exp_wb[2];
  bit retry_m[2];
  vec_t a4, a1, e4, e1;

  // Outputs of an IDLE cycle from the live decode inputs (a miss shows all zeros).
  function automatic vec_t idle_vec();
    vec_t v;
    v = '0;
    if (!(is_load || is_store)) v[8] = 1'b1;
    else if (cache_hit) begin
      v[8] = 1'b1;
      v[5] = is_byte;
      if (is_store) v[6] = 1'b1;
      else          v[7] = 1'b1;
    end
    return v;
  endfunction

  // i-th stall cycle of a miss: lat writeback cycles if dirty, then lat refill
  // cycles with the fill pulse on the last one.
  function automatic vec_t stall_vec(input int lat, input bit dirty, input int i);
    vec_t v;
    v = '0;
    v[0] = 1'b1;
    if (dirty && i < lat) begin
      v[2] = 1'b1;
      v[1] = 1'b1;
    end else begin
      v[3] = 1'b1;
      if (i == (dirty ? 2 * lat : lat) - 1) v[4] = 1'b1;
    end
    return v;
  endfunction

  task automatic model_one(input int d, output vec_t e);
    int lat;
    int n;
    int len;
    lat = (d == 0) ? 4 : 1;
    if (!rst_b) begin
      e = '0;
      if (d == 0) exp_q4.delete(); else exp_q1.delete();
      exp_hit[d] = 0; exp_miss[d] = 0; exp_wb[d] = 0; retry_m[d] = 1'b0;
      return;
    end
    n = (d == 0) ? exp_q4.size() : exp_q1.size();
    if (n != 0) begin
      if (d == 0) e = exp_q4.pop_front(); else e = exp_q1.pop_front();
      if (n == 1) retry_m[d] = 1'b1;
    end else begin
      e = idle_vec();
      if ((is_load || is_store) && cache_hit && !retry_m[d]) exp_hit[d]++;
      if ((is_load || is_store) && !cache_hit) begin
        exp_miss[d]++;
        if (victim_dirty) exp_wb[d]++;
        len = victim_dirty ? 2 * lat : lat;
        for (int i = 0; i < len; i++) begin
          if (d == 0) exp_q4.push_back(stall_vec(lat, victim_dirty, i));
          else        exp_q1.push_back(stall_vec(lat, victim_dirty, i));
        end
      end
      retry_m[d] = 1'b0;
    end
  endtask

  // Sample at negedge, advance the model, then return just after the next posedge
  // so callers drive the following cycle's inputs.
  task automatic tick();
    @(negedge clk);
    a4 = {bus4.pc_we, bus4.reg_we_mem, bus4.cache_we, bus4.cache_byte, bus4.cache_fill,
          bus4.mem_re, bus4.mem_we, bus4.mem_addr_sel, bus4.busy};
    a1 = {bus1.pc_we, bus1.reg_we_mem, bus1.cache_we, bus1.cache_byte, bus1.cache_fill,
          bus1.mem_re, bus1.mem_we, bus1.mem_addr_sel, bus1.busy};
    model_one(0, e4);
    model_one(1, e1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    is_load = 1'b0; is_store = 1'b0; is_byte = 1'b0; cache_hit = 1'b0; victim_dirty = 1'b0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_b = 1'b0;
    drive_idle();
    is_load = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if ({a4, a1} !== 18'b0) begin
        n_bad++;
        $display("FAIL reset_outputs: got L4=%b L1=%b want all zero", a4, a1);
      end
    end
    rst_b = 1'b1;
    is_load = 1'b0;
    tick();
    n_cmp++;
    if (a4 !== 9'b100000000 || a1 !== 9'b100000000) begin
      n_bad++;
      $display("FAIL reset_release_idle: got L4=%b L1=%b want 100000000", a4, a1);
    end
`ifdef MEM_STATS_EN
    n_cmp++;
    if ({bus4.hit_count, bus4.miss_count, bus4.wb_count} !== 96'd0) begin
      n_bad++;
      $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0",
               bus4.hit_count, bus4.miss_count, bus4.wb_count);
    end
`endif
  endtask

  task automatic test_load_hit();
    do_reset();
    drive_idle();
    is_load = 1'b1;
    cache_hit = 1'b1;
    tick();
    n_cmp++;
    if (a4 !== 9'b110000000 || {a4, a1} !== {e4, e1}) begin
      n_bad++;
      $display("FAIL load_hit: got L4=%b L1=%b want L4=%b L1=%b", a4, a1, e4, e1);
    end
`ifdef MEM_STATS_EN
    n_cmp++;
    if (bus4.hit_count !== 32'd1 || bus1.hit_count !== 32'(exp_hit[1])) begin
      n_bad++;
      $display("FAIL load_hit_count: got L4=%0d L1=%0d want 1/%0d",
               bus4.hit_count, bus1.hit_count, exp_hit[1]);
    end
`endif
    drive_idle();
  endtask

  task automatic test_miss(input string name, input bit ld, input bit dirty,
                           input int want4, input int want1, input vec_t want_done);
    int lat4, lat1, re4, wb4, fill4, fill_pos;
    vec_t done4;
    lat4 = -1; lat1 = -1; re4 = 0; wb4 = 0; fill4 = 0; fill_pos = -1; done4 = '0;
    do_reset();
    drive_idle();
    is_load = ld;
    is_store = !ld;
    is_byte = !ld;
    victim_dirty = dirty;
    for (int c = 1; c <= 30 && lat4 < 0; c++) begin
      tick();
      n_cmp++;
      if ({a4, a1} !== {e4, e1}) begin
        n_bad++;
        $display("FAIL %s_cycle%0d: got L4=%b L1=%b want L4=%b L1=%b", name, c, a4, a1, e4, e1);
      end
      if (a4[3]) re4++;
      if (a4[2] && a4[1]) wb4++;
      if (a4[4]) begin fill4++; fill_pos = re4; end
      if (a4[8] && c > 1) begin lat4 = c; done4 = a4; end
      if (a1[8] && c > 1 && lat1 < 0) lat1 = c;
      if (c == 1) begin
        cache_hit = 1'b1;
        victim_dirty = !victim_dirty;
      end
    end
    n_cmp++;
    if (lat4 != want4 || lat1 != want1) begin
      n_bad++;
      $display("FAIL %s_latency: got L4=%0d L1=%0d want L4=%0d L1=%0d", name, lat4, lat1, want4, want1);
    end
    n_cmp++;
    if (re4 != 4 || wb4 != (dirty ? 4 : 0) || fill4 != 1 || fill_pos != 4) begin
      n_bad++;
      $display("FAIL %s_xfers: got re=%0d wb=%0d fill=%0d at %0d want re=4 wb=%0d fill=1 at 4",
               name, re4, wb4, fill4, fill_pos, dirty ? 4 : 0);
    end
    n_cmp++;
    if (done4 !== want_done) begin
      n_bad++;
      $display("FAIL %s_retire: got %b want %b", name, done4, want_done);
    end
`ifdef MEM_STATS_EN
    n_cmp++;
    if (bus4.miss_count !== 32'd1 || bus4.hit_count !== 32'd0 ||
        bus4.wb_count !== 32'(dirty)) begin
      n_bad++;
      $display("FAIL %s_stats: got hit=%0d miss=%0d wb=%0d want 0/1/%0d",
               name, bus4.hit_count, bus4.miss_count, bus4.wb_count, dirty);
    end
`endif
    drive_idle();
  endtask

  task automatic test_reset_mid_refill();
    int fill4;
    fill4 = 0;
    do_reset();
    drive_idle();
    is_store = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      n_cmp++;
      if ({a4, a1} !== {e4, e1}) begin
        n_bad++;
        $display("FAIL rst_refill_cycle%0d: got L4=%b L1=%b want L4=%b L1=%b", c, a4, a1, e4, e1);
      end
      if (a4[4]) fill4++;
      if (c == 3) begin
        n_cmp++;
        if (a4 !== 9'b0) begin
          n_bad++;
          $display("FAIL rst_refill_forced_zero: got %b want 000000000", a4);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if (a4 !== 9'b101000000) begin
          n_bad++;
          $display("FAIL rst_refill_idle_after: got %b want 101000000", a4);
        end
      end
      if (c == 2) rst_b = 1'b0;
      if (c == 3) begin rst_b = 1'b1; cache_hit = 1'b1; end
    end
    n_cmp++;
    if (fill4 != 0) begin
      n_bad++;
      $display("FAIL rst_refill_no_fill: got %0d fill pulses want 0", fill4);
    end
    drive_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst_b        = ($urandom_range(0, 59) != 0);
      is_load      = ($urandom_range(0, 2) != 0);
      is_store     = ($urandom_range(0, 2) == 0);
      is_byte      = $urandom_range(0, 1);
      cache_hit    = ($urandom_range(0, 2) != 0);
      victim_dirty = $urandom_range(0, 1);
      tick();
      n_cmp++;
      if ({a4, a1} !== {e4, e1}) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got L4=%b L1=%b want L4=%b L1=%b", c, a4, a1, e4, e1);
      end
`ifdef MEM_STATS_EN
      n_cmp++;
      if ({bus4.hit_count, bus4.miss_count, bus4.wb_count, bus1.hit_count, bus1.miss_count, bus1.wb_count}
          !== {32'(exp_hit[0]), 32'(exp_miss[0]), 32'(exp_wb[0]),
               32'(exp_hit[1]), 32'(exp_miss[1]), 32'(exp_wb[1])}) begin
        n_bad++;
        $display("FAIL random_stats%0d: got L4 %0d/%0d/%0d L1 %0d/%0d/%0d want L4 %0d/%0d/%0d L1 %0d/%0d/%0d",
                 c, bus4.hit_count, bus4.miss_count, bus4.wb_count,
                 bus1.hit_count, bus1.miss_count, bus1.wb_count,
                 exp_hit[0], exp_miss[0], exp_wb[0], exp_hit[1], exp_miss[1], exp_wb[1]);
      end
`endif
    end
    rst_b = 1'b1;
    drive_idle();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    rst_b = 1'b0;
    drive_idle();
    test_reset();
    test_load_hit();
    test_miss("clean_store_miss", 1'b0, 1'b0, 6, 3, 9'b101100000);
    test_miss("dirty_load_miss", 1'b1, 1'b1, 10, 4, 9'b110000000);
    test_reset_mid_refill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Multi-cycle sequencer for data-memory instructions (LW, SW, LB, SB). It sits between the decode-stage control signals and the data cache / main-memory interface. On a cache hit it completes the access in one cycle. On a miss it stalls the PC, optionally writes back a dirty victim line, refills the line from main memory, and then retries the access.

## Interface
Parameters:
- MEM_LATENCY, 4, cycles main memory needs per line transfer (read or write); legal range ≥1
- CNT_W, $clog2(MEM_LATENCY+1), width of the latency counter

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst_b  in  1  reset; synchronous, active-low
- is_load  in  1  decoded LW/LB in the current instruction
- is_store  in  1  decoded SW/SB in the current instruction
- is_byte  in  1  byte access (LB/SB)
- cache_hit  in  1  tag match for the current address
- victim_dirty  in  1  line selected for replacement is dirty
- pc_we  out  1  PC write enable; instruction may retire
- reg_we_mem  out  1  write the load result to the register file
- cache_we  out  1  store data into cache; sets the line's dirty bit
- cache_byte  out  1  byte-lane write/read select to the cache
- cache_fill  out  1  write mem_rdata line into cache; set valid, clear dirty
- mem_re  out  1  main-memory read (refill)
- mem_we  out  1  main-memory write (victim writeback)
- mem_addr_sel  out  1  0 = requested line address, 1 = victim line address
- busy  out  1  state ≠ IDLE
- hit_count, miss_count, wb_count  out  32 each  statistics counters; present only with MEM_STATS_EN

## Operation
- mem_inst = is_load | is_store. If both are asserted, the access is treated as a store.
- States: IDLE, WRITEBACK, REFILL. Latency counter `cnt`, CNT_W bits.
- IDLE:
  - Non-memory instruction: pc_we = 1; all other outputs 0.
  - mem_inst & cache_hit:
    - pc_we = 1; cache_byte = is_byte.
    - Load: reg_we_mem = 1. Store: cache_we = 1.
    - Stay in IDLE.
  - mem_inst & ~cache_hit:
    - pc_we = 0.
    - If victim_dirty, go to WRITEBACK; otherwise go to REFILL.
    - cnt loads MEM_LATENCY-1.
- WRITEBACK:
  - mem_we = 1 and mem_addr_sel = 1 in every cycle.
  - cnt decrements each cycle. At cnt==0, go to REFILL and reload cnt = MEM_LATENCY-1.
- REFILL:
  - mem_re = 1 and mem_addr_sel = 0 in every cycle.
  - At cnt==0: cache_fill = 1, then go to IDLE.
- Retry: the following IDLE cycle re-evaluates the same instruction, which the stalled PC holds. cache_hit is then 1 and the access completes as a hit.
- pc_we, reg_we_mem and cache_we are 0 in WRITEBACK and REFILL.
- Decode inputs are sampled only in IDLE. Changes to the inputs during WRITEBACK or REFILL are ignored.

## Timing
- While rst_b = 0 at a clock edge, the next state is IDLE and cnt = 0. All outputs are forced to 0 during any cycle in which rst_b = 0.
- Reset asserted mid-WRITEBACK or mid-REFILL aborts the transfer. No cache_fill is issued.
- Hit: 1 cycle. Clean miss: MEM_LATENCY+2 cycles. Dirty miss: 2·MEM_LATENCY+2 cycles. Counts run from the first IDLE cycle of the instruction to the pc_we cycle, inclusive.
- With MEM_LATENCY = 1, WRITEBACK and REFILL each last exactly 1 cycle.
- WRITEBACK → REFILL has no idle cycle between them.
- cache_fill is asserted in the last REFILL cycle only, together with mem_re. mem_rdata is valid in that cycle.
- If the retry cycle still shows a miss (cache fault), the sequencer starts a new miss sequence. No deadlock guard is provided.

## Configuration
- MEM_STATS_EN defined:
  - 32-bit hit_count, miss_count and wb_count are present. They reset to 0 and wrap modulo 2^32.
  - miss_count increments on each IDLE miss detection.
  - wb_count increments on entry to WRITEBACK.
  - hit_count increments on hit cycles, excluding the retry cycle that follows a REFILL.
  - A one-bit retry flag is set on REFILL exit and cleared after the next IDLE cycle.
- MEM_STATS_EN undefined: the counters, the retry flag and the ports are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst_b = 0 for 2 cycles with is_load = 1 → all outputs 0 and busy = 0; after release, state is IDLE.
- Load hit, MEM_LATENCY = 4: is_load = 1, cache_hit = 1 → pc_we = 1 and reg_we_mem = 1 in the same cycle; hit_count = 1.
- Clean store miss, MEM_LATENCY = 4:
  - is_store = 1, is_byte = 1, cache_hit = 0, victim_dirty = 0.
  - Required: mem_re high for 4 cycles; cache_fill only in the 4th; then with cache_hit = 1, cache_we = 1, cache_byte = 1 and pc_we = 1.
  - Total 6 cycles; miss_count = 1, hit_count = 0.
- Dirty load miss, MEM_LATENCY = 4:
  - Required: mem_we with mem_addr_sel = 1 for 4 cycles; then mem_re with mem_addr_sel = 0 for 4 cycles; then reg_we_mem and pc_we.
  - Total 10 cycles; wb_count = 1.
- Reset mid-REFILL: assert rst_b = 0 in the 2nd REFILL cycle → next state IDLE; no cache_fill pulse; pc_we = 0 during reset.
- MEM_LATENCY = 1 dirty miss → WRITEBACK 1 cycle, REFILL 1 cycle with cache_fill; pc_we 4 cycles after the first IDLE cycle.
